// File: rtl/coin_pkg.sv
// Shared constants and FSM encoding for the balance BCD reader.
// Slot geometry defaults match the memory_control packed word.
package coin_pkg;

  localparam int NUM_SLOTS  = 6;
  localparam int SLOT_W     = 8;
  localparam int BCD_DIGITS = 3;
  localparam int BCD_W      = 4 * BCD_DIGITS;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CONVERT = 2'd1;
  localparam logic [1:0] ST_PRESENT = 2'd2;
  localparam logic [1:0] ST_FINISH  = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    CONVERT = ST_CONVERT,
    PRESENT = ST_PRESENT,
    FINISH  = ST_FINISH
  } state_t;

endpackage

// File: rtl/bcd_shift_step.sv
// One double-dabble iteration: add 3 to every nibble >= 5,
// then shift left taking the incoming binary bit.
module bcd_shift_step
  import coin_pkg::*;
(
  input  logic [BCD_W-1:0] acc_i,
  input  logic             bit_i,
  output logic [BCD_W-1:0] acc_o
);

  logic [BCD_W-1:0] adj;

  always_comb begin
    adj = acc_i;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (acc_i[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = acc_i[4*i +: 4] + 4'd3;
    end
  end

  assign acc_o = {adj[BCD_W-2:0], bit_i};

endmodule

// File: rtl/balance_bcd_reader.sv
// Snapshots the packed balance word and streams each slot out
// as three BCD digits over a valid/ready handshake.
module balance_bcd_reader #(
  parameter int NUM_SLOTS = coin_pkg::NUM_SLOTS,
  parameter int SLOT_W    = coin_pkg::SLOT_W
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic [NUM_SLOTS*SLOT_W-1:0] memory_values,
  input  logic                        load_memory,
  input  logic                        digit_ready,
  output logic                        digit_valid,
  output logic [2:0]                  slot_index,
  output logic [3:0]                  bcd_hundreds,
  output logic [3:0]                  bcd_tens,
  output logic [3:0]                  bcd_ones,
  output logic                        busy,
  output logic                        done
);

  localparam int W  = NUM_SLOTS * SLOT_W;
  localparam int BW = coin_pkg::BCD_W;

  coin_pkg::state_t state_q, state_d;

  logic [W-1:0]      snap_q, snap_d;
  logic [BW-1:0]     acc_q, acc_d, step;
  logic [2:0]        bit_q, bit_d;
  logic [2:0]        slot_q, slot_d;
  logic [2:0]        idx_q, idx_d;
  logic [3:0]        hun_q, hun_d;
  logic [3:0]        ten_q, ten_d;
  logic [3:0]        one_q, one_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [SLOT_W-1:0] cur, rot;

  // Current slot sits in the low bits; rotating it SLOT_W times
  // feeds its MSBs in order and leaves it unchanged afterwards.
  assign cur = snap_q[SLOT_W-1:0];
  assign rot = (cur << 1) | (cur >> (SLOT_W - 1));

  bcd_shift_step u_step (
    .acc_i (acc_q),
    .bit_i (cur[SLOT_W-1]),
    .acc_o (step)
  );

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    acc_d   = acc_q;
    bit_d   = bit_q;
    slot_d  = slot_q;
    idx_d   = idx_q;
    hun_d   = hun_q;
    ten_d   = ten_q;
    one_d   = one_q;
    valid_d = valid_q;
    unique case (state_q)
      coin_pkg::IDLE: begin
        if (load_memory) begin
          snap_d  = memory_values;
          slot_d  = 3'd0;
          acc_d   = '0;
          bit_d   = 3'd0;
          state_d = coin_pkg::CONVERT;
        end
      end
      coin_pkg::CONVERT: begin
        acc_d              = step;
        snap_d[SLOT_W-1:0] = rot;
        bit_d              = bit_q + 3'd1;
        if (bit_q == 3'(SLOT_W - 1)) begin
          bit_d   = 3'd0;
          hun_d   = step[11:8];
          ten_d   = step[7:4];
          one_d   = step[3:0];
          idx_d   = slot_q;
          valid_d = 1'b1;
          state_d = coin_pkg::PRESENT;
        end
      end
      coin_pkg::PRESENT: begin
        if (valid_q && digit_ready) begin
          valid_d = 1'b0;
          if (slot_q == 3'(NUM_SLOTS - 1)) begin
            state_d = coin_pkg::FINISH;
          end else begin
            slot_d  = slot_q + 3'd1;
            acc_d   = '0;
            snap_d  = snap_q >> SLOT_W;
            state_d = coin_pkg::CONVERT;
          end
        end
      end
      coin_pkg::FINISH: state_d = coin_pkg::IDLE;
      default:          state_d = coin_pkg::IDLE;
    endcase
    busy_d = (state_d != coin_pkg::IDLE);
    done_d = (state_d == coin_pkg::FINISH);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= coin_pkg::IDLE;
      snap_q  <= '0;
      acc_q   <= '0;
      bit_q   <= 3'd0;
      slot_q  <= 3'd0;
      idx_q   <= 3'd0;
      hun_q   <= 4'd0;
      ten_q   <= 4'd0;
      one_q   <= 4'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      acc_q   <= acc_d;
      bit_q   <= bit_d;
      slot_q  <= slot_d;
      idx_q   <= idx_d;
      hun_q   <= hun_d;
      ten_q   <= ten_d;
      one_q   <= one_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign digit_valid  = valid_q;
  assign slot_index   = idx_q;
  assign bcd_hundreds = hun_q;
  assign bcd_tens     = ten_q;
  assign bcd_ones     = one_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_balance_bcd_reader.sv
// Randomized bench for balance_bcd_reader against a decimal
// reference model of each slot's digits and scan timing.
module tb_balance_bcd_reader;

  logic        clock;
  logic        resetn;
  logic [47:0] memory_values;
  logic        load_memory;
  logic        digit_ready;
  logic        digit_valid;
  logic [2:0]  slot_index;
  logic [3:0]  bcd_hundreds;
  logic [3:0]  bcd_tens;
  logic [3:0]  bcd_ones;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  balance_bcd_reader dut (
    .clock         (clock),
    .resetn        (resetn),
    .memory_values (memory_values),
    .load_memory   (load_memory),
    .digit_ready   (digit_ready),
    .digit_valid   (digit_valid),
    .slot_index    (slot_index),
    .bcd_hundreds  (bcd_hundreds),
    .bcd_tens      (bcd_tens),
    .bcd_ones      (bcd_ones),
    .busy          (busy),
    .done          (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at cyc %0d",
               tag, got, exp, cyc);
    end
  endtask

  // Decimal digits of a balance, packed as slot/hundreds/tens/ones.
  function automatic logic [31:0] ref_slot(input int n,
                                           input logic [7:0] v);
    int h, t, o;
    h = int'(v) / 100;
    t = (int'(v) / 10) % 10;
    o = int'(v) % 10;
    return (n << 12) | (h << 8) | (t << 4) | o;
  endfunction

  function automatic logic [31:0] all_outs();
    return {14'd0, digit_valid, slot_index, bcd_hundreds,
            bcd_tens, bcd_ones, busy, done};
  endfunction

  function automatic logic [31:0] shown();
    return {17'd0, slot_index, bcd_hundreds, bcd_tens, bcd_ones};
  endfunction

  // poke: cycle offset of an ignored second start with word zeroed
  // abort: cycle offset at which reset is asserted mid-scan
  task automatic scan(input logic [47:0] w, input int stall,
                      input int poke, input int abort);
    int k, hold, nslot, ndone, tdone;
    logic [31:0] held;
    bit fin;
    @(negedge clock);
    memory_values = w;
    load_memory   = 1'b1;
    digit_ready   = (stall == 0);
    @(negedge clock);
    load_memory = 1'b0;
    k = cyc;
    chk("busy_start", {31'd0, busy}, 32'd1);
    hold = 0; nslot = 0; ndone = 0; tdone = 0;
    held = '0; fin = 1'b0;
    for (int n = 0; n < 400 && !fin; n++) begin
      @(negedge clock);
      load_memory = (poke > 0 && cyc == k + poke - 1);
      if (load_memory) memory_values = '0;
      if (abort > 0 && cyc == k + abort) begin
        resetn = 1'b0;
        #1;
        chk("abort_zero", all_outs(), 32'd0);
        repeat (3) begin
          @(negedge clock);
          chk("abort_hold", all_outs(), 32'd0);
        end
        resetn      = 1'b1;
        digit_ready = 1'b0;
        return;
      end
      if (done) begin
        ndone++;
        tdone = cyc;
        fin   = 1'b1;
      end
      if (digit_valid) begin
        hold++;
        if (hold > 1) chk("stable", shown(), held);
        held = shown();
        if (stall == 0 || hold > stall) begin
          digit_ready = 1'b1;
          chk("slot", shown(), ref_slot(nslot, w[nslot*8 +: 8]));
          nslot++;
          hold = 0;
        end else begin
          digit_ready = 1'b0;
        end
      end else begin
        hold = 0;
        digit_ready = (stall == 0);
      end
    end
    load_memory = 1'b0;
    chk("nslots", nslot, 6);
    chk("done_seen", ndone, 1);
    chk("done_time", tdone - k, 54 + 6 * stall);
    @(negedge clock);
    chk("idle_after", {30'd0, busy, done}, 32'd0);
    repeat (5) begin
      @(negedge clock);
      chk("stay_idle", {30'd0, busy, done}, 32'd0);
    end
    digit_ready = 1'b0;
  endtask

  initial begin
    logic [47:0] w;
    resetn        = 1'b0;
    load_memory   = 1'b0;
    digit_ready   = 1'b0;
    memory_values = '0;
    repeat (3) @(negedge clock);
    chk("in_reset", all_outs(), 32'd0);
    resetn = 1'b1;
    repeat (10) begin
      @(negedge clock);
      chk("idle", all_outs(), 32'd0);
    end
    scan(48'hFFC8630A0900, 0, 0, 0);
    scan(48'hFFC8630A0900, 5, 0, 0);
    scan({6{8'd128}}, 0, 20, 0);
    scan(48'hFFC8630A0900, 0, 0, 30);
    w = {$urandom, $urandom};
    scan(w, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      w = {$urandom, $urandom};
      scan(w, int'($urandom_range(0, 3)), 0, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
